// File: rtl/types_pkg.sv
// Shared types for the decode stage: fetch/decode records, ALU and
// functional-unit enums, immediate formats and RV32I opcode constants.
package types_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_4;
    } fetch_data;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_BRANCH = 2'd1,
        FU_LSU    = 2'd2
    } fu_type_t;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10,
        ALU_EQ   = 5'd11,
        ALU_NE   = 5'd12,
        ALU_LT   = 5'd13,
        ALU_GE   = 5'd14,
        ALU_LTU  = 5'd15,
        ALU_GEU  = 5'd16
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  opcode;
        fu_type_t    fu_type;
        alu_op_t     alu_op;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        reg_write;
        logic        illegal;
    } decode_data;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: sign-extends the immediate of
// the selected instruction format to 32 bits (R-type / unknown give zero).
module imm_gen
    import types_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_fmt_t    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Single registered RV32I decode stage with valid/ready handshake and flush.
// Define DECODE_ILLEGAL_CHECK_EN to flag unsupported encodings via data_out.illegal.
module decode_stage
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  fetch_data   data_in,
    output logic        ready_in,
    input  logic        flush,
    output logic        valid_out,
    output decode_data  data_out,
    input  logic        ready_out,
    output logic [31:0] decode_count
);

    logic        valid_q, valid_d;
    decode_data  data_q, data_d, dec;
    logic [31:0] count_q, count_d;
    imm_fmt_t    fmt;
    logic [31:0] imm;
    logic        bad;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        f7_zero, f7_alt;

    imm_gen u_imm_gen (
        .instr_i (data_in.instr),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    assign f7      = data_in.instr[31:25];
    assign f3      = data_in.instr[14:12];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);

    always_comb begin
        fmt          = IMM_NONE;
        bad          = 1'b0;
        dec          = '0;
        dec.pc       = data_in.pc;
        dec.pc_4     = data_in.pc_4;
        dec.rd       = data_in.instr[11:7];
        dec.rs1      = data_in.instr[19:15];
        dec.rs2      = data_in.instr[24:20];
        dec.funct3   = f3;
        dec.funct7   = f7;
        dec.opcode   = data_in.instr[6:0];
        dec.fu_type  = FU_ALU;
        dec.alu_op   = ALU_ADD;
        case (data_in.instr[6:0])
            OPC_LUI: begin
                fmt = IMM_U; dec.reg_write = 1'b1; dec.alu_op = ALU_LUI;
            end
            OPC_AUIPC: begin
                fmt = IMM_U; dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                fmt = IMM_J; dec.reg_write = 1'b1; dec.fu_type = FU_BRANCH;
            end
            OPC_JALR: begin
                fmt = IMM_I; dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1;
                dec.fu_type = FU_BRANCH;
                bad = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt = IMM_B; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                dec.fu_type = FU_BRANCH;
                case (f3)
                    3'b000:  dec.alu_op = ALU_EQ;
                    3'b001:  dec.alu_op = ALU_NE;
                    3'b100:  dec.alu_op = ALU_LT;
                    3'b101:  dec.alu_op = ALU_GE;
                    3'b110:  dec.alu_op = ALU_LTU;
                    3'b111:  dec.alu_op = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt = IMM_I; dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1;
                dec.fu_type = FU_LSU;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                fmt = IMM_S; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                dec.fu_type = FU_LSU;
                bad = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1;
                case (f3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b001:  begin dec.alu_op = ALU_SLL; bad = !f7_zero; end
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101:  begin
                        dec.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        bad = !(f7_zero || f7_alt);
                    end
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                // funct7=0100000 is only meaningful for SUB and SRA
                bad = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
                case (f3)
                    3'b000:  dec.alu_op = f7_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu_op = ALU_SLL;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101:  dec.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            default: bad = 1'b1;
        endcase
        dec.imm = imm;
        if (bad) begin
            dec.fu_type   = FU_ALU;
            dec.alu_op    = ALU_ADD;
            dec.reg_write = 1'b0;
            dec.uses_rs1  = 1'b0;
            dec.uses_rs2  = 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
            dec.illegal   = 1'b1;
`else
            dec.illegal   = 1'b0;
`endif
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    assign ready_in = !valid_q || ready_out;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        // A flush discards the held record, so it is not counted even if ready_out is high
        if (flush) begin
            valid_d = 1'b0;
        end else begin
            if (valid_q && ready_out) begin
                count_d = count_q + 32'd1;
            end
            if (ready_in) begin
                valid_d = valid_in;
                if (valid_in) begin
                    data_d = dec;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign decode_count = count_q;

endmodule
